// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory, with a bounded burst lock for m1.
// Optional grant/conflict counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       stat_m0_grants,
    output logic [15:0]       stat_m1_grants,
    output logic [15:0]       stat_conflicts,
`endif
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic       prio_q, prio_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rvalid_q, rvalid_d;
    logic       owner_q, owner_d;

    logic both_req;
    logic lock_act;
    logic burst_full;
    logic gnt0;
    logic gnt1;
    logic sel_we;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        both_req   = m0_req & m1_req;
        lock_act   = m1_req & m1_lock;
        burst_full = (burst_cnt_q >= BURST_LIM);
        if (reset) begin
            if (both_req) begin
                // Under lock m1 wins until the burst budget is spent, then m0 gets one slot.
                if (m1_lock) begin
                    gnt1 = ~burst_full;
                    gnt0 = burst_full;
                end else begin
                    gnt1 = prio_q;
                    gnt0 = ~prio_q;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        sel_we  = gnt1 ? m1_we    : m0_we;
        addr    = gnt1 ? m1_addr  : m0_addr;
        wr_data = gnt1 ? m1_wdata : m0_wdata;
        wr      = (gnt0 | gnt1) & sel_we;
        rd      = (gnt0 | gnt1) & ~sel_we;
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rdata  = rd_data;
    assign m1_rdata  = rd_data;
    assign m0_rvalid = rvalid_q & ~owner_q;
    assign m1_rvalid = rvalid_q & owner_q;

    always_comb begin
        prio_d = prio_q;
        if (lock_act) begin
            prio_d = 1'b1;
        end else if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end

        // Saturating at the limit lets an uncontended burst run forever.
        burst_cnt_d = burst_cnt_q;
        if (!lock_act) begin
            burst_cnt_d = 4'd0;
        end else if (gnt1) begin
            burst_cnt_d = burst_full ? BURST_LIM : burst_cnt_q + 4'd1;
        end else if (gnt0) begin
            burst_cnt_d = 4'd0;
        end

        rvalid_d = rd;
        owner_d  = gnt1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q      <= 1'b0;
            burst_cnt_q <= 4'd0;
            rvalid_q    <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            owner_q     <= owner_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st_m0_q, st_m0_d;
    logic [15:0] st_m1_q, st_m1_d;
    logic [15:0] st_cf_q, st_cf_d;

    always_comb begin
        st_m0_d = st_m0_q + 16'(gnt0);
        st_m1_d = st_m1_q + 16'(gnt1);
        st_cf_d = st_cf_q + 16'(both_req);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_m0_q <= 16'd0;
            st_m1_q <= 16'd0;
            st_cf_q <= 16'd0;
        end else begin
            st_m0_q <= st_m0_d;
            st_m1_q <= st_m1_d;
            st_cf_q <= st_cf_d;
        end
    end

    assign stat_m0_grants = st_m0_q;
    assign stat_m1_grants = st_m1_q;
    assign stat_conflicts = st_cf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized traffic against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int BMAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
`ifdef DMEM_ARB_STATS_EN
        .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
        .stat_conflicts(stat_conflicts),
`endif
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {7'h35, a, ~a, 7'h11};
    endfunction

    // Memory behind the arbiter, driven only by the DUT's memory-side port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            seen [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (wr) begin
            mem[addr]  <= wr_data;
            seen[addr] <= 1'b1;
        end
        if (rd) rd_data <= seen[addr] ? mem[addr] : pat(addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model state: favoured requester, length of m1's current locked streak,
    // the outstanding read, and the expected memory contents.
    bit            ref_favour_m1;
    int            ref_streak;
    bit            ref_rv;
    bit            ref_rv_m1;
    logic [DW-1:0] ref_rv_data;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_seen [0:(1<<AW)-1];
    logic [15:0]   ref_s0, ref_s1, ref_sc;

    int            last_g;
    logic          cap_rv0, cap_rv1;
    logic [DW-1:0] cap_rdata;

    task automatic model_reset();
        ref_favour_m1 = 1'b0;
        ref_streak    = 0;
        ref_rv        = 1'b0;
        ref_rv_m1     = 1'b0;
        ref_s0 = '0; ref_s1 = '0; ref_sc = '0;
    endtask

    task automatic step();
        int            g;
        bit            we;
        logic [AW-1:0] a;
        @(negedge clk);
        g = -1;
        if (reset) begin
            if (m0_req && m1_req) begin
                if (m1_lock) g = (ref_streak >= BMAX) ? 0 : 1;
                else         g = ref_favour_m1 ? 1 : 0;
            end else if (m0_req) g = 0;
            else if (m1_req)     g = 1;
        end
        we = (g == 1) ? m1_we : m0_we;
        a  = (g == 1) ? m1_addr : m0_addr;
        check_eq("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        check_eq("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        check_eq("wr", 32'(wr), 32'(g >= 0 && we));
        check_eq("rd", 32'(rd), 32'(g >= 0 && !we));
        check_eq("addr", 32'(addr), 32'(a));
        if (g >= 0 && we) check_eq("wr_data", wr_data, (g == 1) ? m1_wdata : m0_wdata);
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(ref_rv && !ref_rv_m1));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(ref_rv && ref_rv_m1));
        if (ref_rv) begin
            check_eq("m0_rdata", m0_rdata, ref_rv_data);
            check_eq("m1_rdata", m1_rdata, ref_rv_data);
        end
`ifdef DMEM_ARB_STATS_EN
        check_eq("stat_m0", 32'(stat_m0_grants), 32'(ref_s0));
        check_eq("stat_m1", 32'(stat_m1_grants), 32'(ref_s1));
        check_eq("stat_cf", 32'(stat_conflicts), 32'(ref_sc));
`endif
        last_g    = g;
        cap_rv0   = m0_rvalid;
        cap_rv1   = m1_rvalid;
        cap_rdata = m0_rdata;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (m0_req && m1_req) ref_sc++;
            if (g == 0) ref_s0++;
            if (g == 1) ref_s1++;
            ref_rv    = (g >= 0) && !we;
            ref_rv_m1 = (g == 1);
            if (ref_rv) ref_rv_data = ref_seen[a] ? ref_mem[a] : pat(a);
            if (g >= 0 && we) begin
                ref_mem[a]  = (g == 1) ? m1_wdata : m0_wdata;
                ref_seen[a] = 1'b1;
            end
            if (m1_req && m1_lock) ref_favour_m1 = 1'b1;
            else if (g == 0)       ref_favour_m1 = 1'b1;
            else if (g == 1)       ref_favour_m1 = 1'b0;
            if (!(m1_req && m1_lock)) ref_streak = 0;
            else if (g == 1)          ref_streak = (ref_streak + 1 > BMAX) ? BMAX : ref_streak + 1;
            else if (g == 0)          ref_streak = 0;
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int lock_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        // Bring flops out of X before the model takes over.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        check_eq("rst_no_gnt", 32'(last_g), 32'(-1));
        check_eq("rst_rvalid", 32'({cap_rv0, cap_rv1}), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        reset = 1'b1;

        // CPU write then read-back.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd20; m0_wdata = 32'hDEADBEEF;
        step();
        check_eq("wr_gnt", 32'(last_g), 32'd0);
        m0_we = 1'b0;
        step();
        check_eq("rd_gnt", 32'(last_g), 32'd0);
        m0_req = 1'b0;
        step();
        check_eq("rb_rvalid", 32'({cap_rv0, cap_rv1}), 32'b10);
        check_eq("rb_rdata", cap_rdata, 32'hDEADBEEF);

        // Alternating reads with no lock.
        pulse_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd40;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd41;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("alt_gnt", 32'(last_g), 32'(i % 2));
        end

        // Locked burst with contention.
        pulse_reset();
        m1_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("lock_gnt", 32'(last_g), 32'(lock_seq[i]));
        end

        // Locked burst without contention, then m0 arrives against a saturated streak.
        m0_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("solo_gnt", 32'(last_g), 32'd1);
        end
        m0_req = 1'b1;
        step();
        check_eq("sat_gnt", 32'(last_g), 32'd0);
        m1_lock = 1'b0; m1_req = 1'b0;

        // Reset asserted alongside an m0 read.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd20;
        reset = 1'b0;
        step();
        check_eq("rstrd_gnt", 32'(last_g), 32'(-1));
        reset = 1'b1; m0_req = 1'b0;
        step();
        check_eq("rstrd_rvalid", 32'({cap_rv0, cap_rv1}), 32'd0);
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        check_eq("post_rst_gnt", 32'(last_g), 32'd0);

`ifdef DMEM_ARB_STATS_EN
        pulse_reset();
        repeat (6) step();
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        check_eq("st_conf6", 32'(stat_conflicts), 32'd6);
        check_eq("st_m0_3", 32'(stat_m0_grants), 32'd3);
        check_eq("st_m1_3", 32'(stat_m1_grants), 32'd3);
`endif

        // Randomized traffic: requests held until granted, occasional lock flips and resets.
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!m0_req || last_g == 0) begin
                m0_req   = ($urandom_range(0, 3) != 0);
                m0_we    = $urandom_range(0, 1) == 1;
                m0_addr  = 9'($urandom_range(0, 31));
                m0_wdata = $urandom;
            end
            if (!m1_req || last_g == 1) begin
                m1_req   = ($urandom_range(0, 3) != 0);
                m1_we    = $urandom_range(0, 1) == 1;
                m1_addr  = 9'($urandom_range(0, 31));
                m1_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) m1_lock = ~m1_lock;
            reset = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Requester 0 is the CPU MEM stage; requester 1 is a DMA/debug port used by benches and loaders.
- Applies round-robin arbitration with an optional bounded burst lock for requester 1.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the pipeline MEM stage and the data memory. Memory-side signals keep the existing wr/rd/addr/wr_data/rd_data names.

Parameters:
- ADDR_W, 9, word address width.
- DATA_W, 32, data width.
- BURST_MAX, 4, maximum consecutive locked grants to requester 1 while requester 0 is waiting (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- m0_req  in  1  CPU request, held until granted.
- m0_we  in  1  CPU write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_gnt  out  1  CPU granted this cycle; m0_req & ~m0_gnt is the pipeline stall.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- m1_req  in  1  DMA request.
- m1_we  in  1  DMA write enable.
- m1_lock  in  1  DMA burst lock request.
- m1_addr  in  ADDR_W  DMA address.
- m1_wdata  in  DATA_W  DMA write data.
- m1_gnt  out  1  DMA granted this cycle.
- m1_rvalid  out  1  DMA read data valid.
- m1_rdata  out  DATA_W  DMA read data.
- wr  out  1  memory write strobe.
- rd  out  1  memory read strobe.
- addr  out  ADDR_W  memory address.
- wr_data  out  DATA_W  memory write data.
- rd_data  in  DATA_W  memory read data, valid the cycle after rd.

Behaviour:
- Handshake: a transfer occurs in a cycle where reqX & gntX are both 1. The requester holds req, we, addr and wdata stable until granted. At most one gnt is high per cycle.
- Grant logic is combinational from the current requests and registered state:
  - Only one requester active: it is granted.
  - Both active: the requester selected by the priority pointer `prio` is granted.
- `prio` (1 bit, 0 = m0 favoured) updates on each grant to favour the requester not granted.
  - Exception: while m1 holds a lock, `prio` stays at 1.
- Memory drive:
  - addr and wr_data are muxed from the granted requester. When nothing is granted, they take m0's values.
  - wr = granted & we.
  - rd = granted & ~we.
  - wr and rd are never both 1.
- Burst lock: a 4-bit counter `burst_cnt` tracks consecutive m1 grants while m1_lock=1.
  - While m1_lock=1 and burst_cnt < BURST_MAX, m1 has priority over m0.
  - Reaching BURST_MAX with m0_req=1 forces one grant to m0. burst_cnt then clears and the lock may resume.
  - burst_cnt clears when m1_lock=0 or m1_req=0.
  - burst_cnt saturates at BURST_MAX when m0 is idle, so an unlimited burst is allowed if there is no contention.
- Read return: a 1-bit valid and a 1-bit owner tag are registered when rd=1.
  - Next cycle, rvalid of the owning requester = 1 and the other rvalid = 0.
  - m0_rdata = m1_rdata = rd_data at all times; only rvalid qualifies the data.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Reset (reset=0 at a clock edge):
  - prio=0, burst_cnt=0, pending read valid=0.
  - m0_rvalid=m1_rvalid=0 from the next cycle.
  - While reset=0, m0_gnt, m1_gnt, wr and rd are forced to 0.
  - A read granted in the cycle reset asserts produces no rvalid.
- Writes produce no response; the write completes in the grant cycle.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three extra outputs are added:
  - stat_m0_grants (16 bits): counts m0 grants.
  - stat_m1_grants (16 bits): counts m1 grants.
  - stat_conflicts (16 bits): counts cycles with both req=1.
- All three counters wrap at 2^16, clear on reset, and do not alter arbitration.
- When the macro is undefined, these ports and counters do not exist. The logic is otherwise identical.

Test Plan:
- Single CPU write then read, m0_addr=9'd20, m0_wdata=32'hDEADBEEF:
  - m0_gnt=1 each cycle; wr=1 then rd=1.
  - Next cycle m0_rvalid=1 and m0_rdata=32'hDEADBEEF; m1_rvalid stays 0.
- Both requesting reads continuously, no lock, from reset: grants alternate m0,m1,m0,m1. rvalid alternates m0,m1 one cycle later, and each rdata matches its own address.
- m1_lock=1, BURST_MAX=4, both requesting: grant sequence is m1,m1,m1,m1,m0,m1,m1,m1,m1,m0.
- m1_lock=1 with m0_req=0 for 10 cycles: m1 granted all 10 cycles; burst_cnt saturates at 4.
- m0 read granted in cycle N, reset=0 in cycle N:
  - No rvalid in cycle N+1.
  - During reset all gnt, wr and rd = 0.
  - After release, both requesting gives the first grant to m0.
- With DMEM_ARB_STATS_EN, 6 cycles of both-requesting: stat_conflicts=6, stat_m0_grants=3, stat_m1_grants=3.
